// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush scheduler for the 5-stage RV32 pipeline (load-use, redirect, D$ busy, divide).
// Define PIPE_CTRL_PERF_EN to build the frozen-fetch cycle counter behind StallCycles.
module pipeline_ctrl #(
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        LoadUseStall,
    input  logic        PCSrcE,
    input  logic        DCacheBusy,
    input  logic        DivStartE,
    output logic        EnF,
    output logic        EnD,
    output logic        EnE,
    output logic        EnM,
    output logic        EnW,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        FlushW,
    output logic        DivBusy,
    output logic        DivDone,
    output logic        MemTimeout,
    output logic [31:0] StallCycles
);

    localparam int unsigned DW = $clog2(DIV_CYCLES);
    localparam logic [DW-1:0] DCNT_INIT = DW'(DIV_CYCLES - 2);
    localparam logic [7:0]    MT_LAST   = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DIV} state_t;

    state_t        state, state_nx;
    logic [7:0]    mcnt, mcnt_nx;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic          run_rules;
    logic          allow_div;
    logic          tmo_set;

    always_comb begin
        EnF       = 1'b1;
        EnD       = 1'b1;
        EnE       = 1'b1;
        EnM       = 1'b1;
        EnW       = 1'b1;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        FlushW    = 1'b0;
        DivBusy   = 1'b0;
        DivDone   = 1'b0;
        state_nx  = state;
        mcnt_nx   = mcnt;
        dcnt_nx   = dcnt;
        run_rules = 1'b0;
        allow_div = 1'b0;
        tmo_set   = 1'b0;

        case (state)
            RUN, MEM_WAIT: begin
                run_rules = 1'b1;
                allow_div = 1'b1;
            end
            DIV: begin
                DivBusy = 1'b1;
                if (dcnt != '0) begin
                    // Divide still owns Execute: every other request is masked.
                    EnF     = 1'b0;
                    EnD     = 1'b0;
                    EnE     = 1'b0;
                    FlushM  = 1'b1;
                    dcnt_nx = dcnt - 1'b1;
                end else begin
                    DivDone   = 1'b1;
                    run_rules = 1'b1;
                    state_nx  = RUN;
                end
            end
            default: state_nx = RUN;
        endcase

        if (run_rules) begin
            if (DCacheBusy) begin
                EnF      = 1'b0;
                EnD      = 1'b0;
                EnE      = 1'b0;
                EnM      = 1'b0;
                FlushW   = 1'b1;
                state_nx = MEM_WAIT;
                mcnt_nx  = (mcnt == 8'hFF) ? mcnt : mcnt + 8'd1;
                tmo_set  = (mcnt >= MT_LAST);
            end else begin
                mcnt_nx  = '0;
                state_nx = RUN;
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (LoadUseStall) begin
                    EnF    = 1'b0;
                    EnD    = 1'b0;
                    FlushE = 1'b1;
                end else if (DivStartE && allow_div) begin
                    EnF      = 1'b0;
                    EnD      = 1'b0;
                    EnE      = 1'b0;
                    FlushM   = 1'b1;
                    state_nx = DIV;
                    dcnt_nx  = DCNT_INIT;
                end
            end
        end

        if (!rst_n) begin
            EnF     = 1'b0;
            EnD     = 1'b0;
            EnE     = 1'b0;
            EnM     = 1'b0;
            EnW     = 1'b0;
            FlushD  = 1'b1;
            FlushE  = 1'b1;
            FlushM  = 1'b1;
            FlushW  = 1'b1;
            DivBusy = 1'b0;
            DivDone = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            mcnt       <= '0;
            dcnt       <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state <= state_nx;
            mcnt  <= mcnt_nx;
            dcnt  <= dcnt_nx;
            if (tmo_set)
                MemTimeout <= 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] scnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            scnt <= '0;
        else if (!EnF)
            scnt <= scnt + 32'd1;
    end

    assign StallCycles = scnt;
`else
    assign StallCycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, timeout/reset sequences,
// and randomized traffic against a cycle-index reference model.
module tb_pipeline_ctrl;

    localparam int DC = 4;
    localparam int MT = 3;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        LoadUseStall = 1'b0, PCSrcE = 1'b0, DCacheBusy = 1'b0, DivStartE = 1'b0;
    logic        EnF, EnD, EnE, EnM, EnW, FlushD, FlushE, FlushM, FlushW;
    logic        DivBusy, DivDone, MemTimeout;
    logic [31:0] StallCycles;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl #(.DIV_CYCLES(DC), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst_n(rst_n),
        .LoadUseStall(LoadUseStall), .PCSrcE(PCSrcE), .DCacheBusy(DCacheBusy), .DivStartE(DivStartE),
        .EnF(EnF), .EnD(EnD), .EnE(EnE), .EnM(EnM), .EnW(EnW),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
        .DivBusy(DivBusy), .DivDone(DivDone), .MemTimeout(MemTimeout), .StallCycles(StallCycles)
    );

    always #5 clk = ~clk;

    // Reference model: busy run length, divide occupancy index (-1 = none), sticky timeout, stall count.
    int          m_busy_run;
    int          m_div_k;
    bit          m_tmo;
    int unsigned m_stalls;

    function automatic logic [10:0] outs();
        return {EnF, EnD, EnE, EnM, EnW, FlushD, FlushE, FlushM, FlushW, DivBusy, DivDone};
    endfunction

    function automatic logic [10:0] model_out(bit lu, bit pc, bit bz, bit ds);
        logic [4:0] en = 5'b11111;
        logic [3:0] fl = 4'b0000;
        bit masked = (m_div_k >= 1) && (m_div_k <= DC - 2);
        bit busy   = (m_div_k >= 1);
        bit done   = (m_div_k == DC - 1);
        if (masked) begin
            en = 5'b00011; fl = 4'b0010;
        end else if (bz) begin
            en = 5'b00001; fl = 4'b0001;
        end else if (pc) begin
            fl = 4'b1100;
        end else if (lu) begin
            en = 5'b00111; fl = 4'b0100;
        end else if (ds && !done) begin
            en = 5'b00011; fl = 4'b0010;
        end
        return {en, fl, busy, done};
    endfunction

    task automatic model_reset();
        m_busy_run = 0;
        m_div_k    = -1;
        m_tmo      = 1'b0;
        m_stalls   = 0;
    endtask

    task automatic model_step(bit lu, bit pc, bit bz, bit ds);
        logic [10:0] o = model_out(lu, pc, bz, ds);
        bit masked = (m_div_k >= 1) && (m_div_k <= DC - 2);
        if (!o[10]) m_stalls++;
        if (masked) begin
            m_div_k++;
        end else if (bz) begin
            m_busy_run = (m_busy_run < 255) ? m_busy_run + 1 : 255;
            if (m_busy_run >= MT) m_tmo = 1'b1;
            m_div_k = -1;
        end else begin
            m_busy_run = 0;
            if (!pc && !lu && ds && m_div_k != DC - 1) m_div_k = 1;
            else m_div_k = -1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_regs(input string name);
        check({name, ".tmo"}, {31'd0, MemTimeout}, {31'd0, m_tmo});
        check({name, ".stall"}, StallCycles, PERF ? m_stalls : 32'd0);
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled near the falling edge.
    task automatic apply(bit lu, bit pc, bit bz, bit ds);
        LoadUseStall = lu; PCSrcE = pc; DCacheBusy = bz; DivStartE = ds;
        #4;
    endtask

    task automatic advance(bit lu, bit pc, bit bz, bit ds);
        @(posedge clk);
        model_step(lu, pc, bz, ds);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        LoadUseStall = 0; PCSrcE = 0; DCacheBusy = 0; DivStartE = 0;
        #1;
        check("rst.outs", {21'd0, outs()}, {21'd0, 11'b00000_1111_00});
        check("rst.tmo", {31'd0, MemTimeout}, 32'd0);
        check("rst.stall", StallCycles, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit lu, pc, bz, ds;
        logic [10:0] exp;
    } vec_t;

    localparam logic [10:0] IDLE  = 11'b11111_0000_00;
    localparam logic [10:0] LU    = 11'b00111_0100_00;
    localparam logic [10:0] REDIR = 11'b11111_1100_00;
    localparam logic [10:0] MEMF  = 11'b00001_0001_00;
    localparam logic [10:0] DENT  = 11'b00011_0010_00;
    localparam logic [10:0] DHOLD = 11'b00011_0010_10;
    localparam logic [10:0] DDONE = 11'b11111_0000_11;

    vec_t tab[25];

    function automatic vec_t mk(bit lu, bit pc, bit bz, bit ds, logic [10:0] e);
        vec_t v;
        v.lu = lu; v.pc = pc; v.bz = bz; v.ds = ds; v.exp = e;
        return v;
    endfunction

    initial begin
        bit lu, pc, bz, ds;

        tab[0]  = mk(0, 0, 0, 0, IDLE);
        tab[1]  = mk(1, 0, 0, 0, LU);
        tab[2]  = mk(0, 0, 0, 0, IDLE);
        tab[3]  = mk(1, 1, 0, 0, REDIR);
        for (int i = 4; i <= 8; i++) tab[i] = mk(0, 1, 1, 0, MEMF);
        tab[9]  = mk(0, 1, 0, 0, REDIR);
        tab[10] = mk(0, 0, 0, 0, IDLE);
        tab[11] = mk(0, 0, 0, 1, DENT);
        tab[12] = mk(0, 0, 0, 0, DHOLD);
        tab[13] = mk(0, 0, 1, 0, DHOLD);
        tab[14] = mk(0, 0, 0, 0, DDONE);
        tab[15] = mk(0, 0, 0, 0, IDLE);
        tab[16] = mk(0, 0, 0, 1, DENT);
        tab[17] = mk(0, 0, 0, 1, DHOLD);
        tab[18] = mk(0, 0, 0, 1, DHOLD);
        tab[19] = mk(0, 0, 0, 1, DDONE);
        tab[20] = mk(0, 0, 0, 1, DENT);
        tab[21] = mk(1, 1, 1, 0, DHOLD);
        tab[22] = mk(0, 0, 0, 0, DHOLD);
        tab[23] = mk(0, 0, 0, 0, DDONE);
        tab[24] = mk(0, 0, 0, 0, IDLE);

        // Reset held over several edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst.hold", {21'd0, outs()}, {21'd0, 11'b00000_1111_00});
        check("rst.hold.tmo", {31'd0, MemTimeout}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tab[i]) begin
            apply(tab[i].lu, tab[i].pc, tab[i].bz, tab[i].ds);
            check($sformatf("tab[%0d]", i), {21'd0, outs()}, {21'd0, tab[i].exp});
            check_regs($sformatf("tab[%0d]", i));
            advance(tab[i].lu, tab[i].pc, tab[i].bz, tab[i].ds);
        end

        // Timeout: flag rises after the third consecutive busy cycle and sticks.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            apply(0, 0, 1, 0);
            check($sformatf("tmo.busy%0d", i), {21'd0, outs()}, {21'd0, MEMF});
            advance(0, 0, 1, 0);
            check($sformatf("tmo.after%0d", i), {31'd0, MemTimeout}, (i >= 3) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            apply(0, 0, 0, 0);
            check("tmo.idle", {21'd0, outs()}, {21'd0, IDLE});
            advance(0, 0, 0, 0);
            check("tmo.sticky", {31'd0, MemTimeout}, 32'd1);
        end
        apply(0, 0, 1, 0);
        advance(0, 0, 1, 0);
        apply(0, 0, 1, 0);
        do_reset();
        apply(0, 0, 0, 0);
        check("tmo.rst.run", {21'd0, outs()}, {21'd0, IDLE});
        check("tmo.rst.cleared", {31'd0, MemTimeout}, 32'd0);
        advance(0, 0, 0, 0);

        // Stall counting: two load-use cycles plus one divide freeze fetch for five cycles.
        do_reset();
        foreach (tab[i]) begin
            if (i < 6) begin
                lu = (i < 2); ds = (i == 2);
                apply(lu, 0, 0, ds);
                advance(lu, 0, 0, ds);
            end
        end
        check("perf.count", StallCycles, PERF ? 32'd5 : 32'd0);
        check_regs("perf");

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            lu = ($urandom_range(0, 3) == 0);
            pc = ($urandom_range(0, 4) == 0);
            bz = ($urandom_range(0, 4) == 0);
            ds = ($urandom_range(0, 5) == 0);
            apply(lu, pc, bz, ds);
            check($sformatf("rnd[%0d]", i), {21'd0, outs()}, {21'd0, model_out(lu, pc, bz, ds)});
            check_regs($sformatf("rnd[%0d]", i));
            advance(lu, pc, bz, ds);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RV32 pipeline.
- Merges the hazard unit's load-use stall and branch redirect, data-cache busy, and a multi-cycle divide occupying Execute.
- Produces per-stage register enables and bubble-injects.
- Holds the small FSM and counters that sequence multi-cycle freezes.

Parameters:
- DIV_CYCLES, 32, total cycles a divide occupies Execute, including the entry cycle; legal range ≥2.
- MEM_TIMEOUT, 255, consecutive DCacheBusy cycles before MemTimeout is flagged; legal range 1..255.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- LoadUseStall  in  1  load-use hazard detected (Stall from hazard unit).
- PCSrcE  in  1  taken branch/jump resolved in Execute (Flush request).
- DCacheBusy  in  1  Memory-stage access not complete this cycle.
- DivStartE  in  1  divide/remainder instruction present in Execute.
- EnF  out  1  PC register enable.
- EnD  out  1  F/D register enable.
- EnE  out  1  D/E register enable.
- EnM  out  1  E/M register enable.
- EnW  out  1  M/W register enable.
- FlushD  out  1  clear F/D register; overrides EnD.
- FlushE  out  1  clear D/E register; overrides EnE.
- FlushM  out  1  clear E/M register; overrides EnM.
- FlushW  out  1  clear M/W register; overrides EnW.
- DivBusy  out  1  divide in progress; high in state DIV.
- DivDone  out  1  one-cycle pulse on the final divide cycle.
- MemTimeout  out  1  sticky error flag.
- StallCycles  out  32  frozen-fetch cycle count.

Behaviour:
- States: RUN, MEM_WAIT, DIV.
- Counters: 8-bit memory-wait counter mcnt; divide counter dcnt, width clog2(DIV_CYCLES).
- Reset, while rst_n low, asynchronous:
  - state=RUN, mcnt=0, dcnt=0, MemTimeout=0, StallCycles=0.
  - All En*=0, all Flush*=1, DivBusy=0, DivDone=0.
- Outputs are combinational from state and inputs. Default: all En*=1, all Flush*=0.
- Priority when not in DIV: DCacheBusy > PCSrcE > LoadUseStall > DivStartE.
- DCacheBusy=1, in RUN or MEM_WAIT:
  - EnF=EnD=EnE=EnM=0, FlushW=1 (bubble into W).
  - Effective in the same cycle busy rises.
  - Next state MEM_WAIT; mcnt increments, saturating.
  - When mcnt reaches MEM_TIMEOUT, MemTimeout sets and stays set until reset; the freeze continues.
- DCacheBusy=0 in MEM_WAIT:
  - Normal RUN rules apply this cycle; next state RUN, mcnt=0.
  - PCSrcE/LoadUseStall held during the freeze take effect now (the Execute contents were frozen, so the request is still asserted).
- PCSrcE=1, not busy: FlushD=1, FlushE=1. LoadUseStall is ignored, since the Decode instruction is wrong-path.
- LoadUseStall=1, not busy, no PCSrcE: EnF=0, EnD=0, FlushE=1.
- DivStartE=1 in RUN, no busy, no PCSrcE:
  - EnF=EnD=EnE=0, FlushM=1.
  - Next state DIV, dcnt=DIV_CYCLES-2.
  - LoadUseStall is ignored this cycle.
- DIV state with dcnt≠0:
  - DivBusy=1, EnF=EnD=EnE=0, FlushM=1, dcnt decrements.
  - DCacheBusy, PCSrcE, LoadUseStall and DivStartE are all masked (Memory holds bubbles).
- DIV state with dcnt=0:
  - DivBusy=1, DivDone=1; RUN rules apply (the divide leaves Execute); next state RUN.
  - DivStartE is not re-evaluated this cycle.
- Execute occupancy of a divide is exactly DIV_CYCLES cycles. Back-to-back divides restart from RUN on the following cycle.
- An illegal state returns to RUN on the next edge.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined: StallCycles increments on every post-reset cycle where EnF=0 and rst_n=1; wraps 0xFFFFFFFF→0.
- Undefined: StallCycles is tied to 0 and no counter flop is synthesized.

Test Plan:
- Reset: rst_n=0 with clk running → all En*=0, Flush*=1, MemTimeout=0. Release rst_n → all En*=1, Flush*=0.
- Load-use versus redirect:
  - LoadUseStall=1 for 1 cycle → EnF=EnD=0, FlushE=1 that cycle only.
  - LoadUseStall=1 and PCSrcE=1 together → FlushD=FlushE=1, EnF=EnD=1.
- Cache stall with pending branch:
  - DCacheBusy=1 for 5 cycles with PCSrcE=1 → EnF..EnM=0, FlushW=1, FlushD=FlushE=0 for 5 cycles.
  - On the 6th cycle (busy low) → FlushD=FlushE=1.
- Divide, DIV_CYCLES=4: DivStartE=1 at cycle 0 →
  - EnE=0, FlushM=1 on cycles 0–2.
  - DivDone=1 on cycle 3 only; DivBusy=1 on cycles 1–3.
  - DCacheBusy pulsed during cycle 2 has no effect.
- Timeout, MEM_TIMEOUT=3: DCacheBusy held 10 cycles → MemTimeout rises after the 3rd busy cycle and stays 1 after busy drops. Asserting rst_n=0 mid-wait clears it and returns to RUN.
- PIPE_CTRL_PERF_EN defined:
  - 2 load-use cycles, then a divide with DIV_CYCLES=4 → StallCycles=5.
  - Preloaded 0xFFFFFFFF plus one stall cycle → 0.
